pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum data-memory wait cycles before the error state; legal range 1..15.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_rs1, id_rs2  in  5 each  source register fields of the instruction in ID.
REQ-005 id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-006 ex_rd  in  5  destination register of the instruction in EX.
REQ-007 ex_memread  in  1  EX instruction is a load.
REQ-008 ex_redirect  in  1  EX resolved a taken branch, jal or jalr (NPCOp non-zero).
REQ-009 mem_acc  in  1  MEM-stage instruction is a load or store.
REQ-010 dmem_ready  in  1  data memory completes the current access this cycle.
REQ-011 dmem_req  out  1  data-memory request, held until dmem_ready.
REQ-012 pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold the respective register.
REQ-013 memwb_bubble  out  1  load a NOP into MEM/WB.
REQ-014 ifid_flush, idex_flush  out  1 each  clear the respective register to NOP.
REQ-015 mem_err  out  1  sticky memory-timeout flag.
REQ-016 stall_cnt  out  32  count of cycles with pc_stall high.

Function
REQ-017 Memory FSM states: IDLE, BUSY, ERR.
REQ-018 IDLE: dmem_req = mem_acc. mem_acc with dmem_ready in the same cycle is a zero-wait access: no stall, stay IDLE.
REQ-019 IDLE with mem_acc and no dmem_ready: go to BUSY and clear wait_cnt to 0.
REQ-020 BUSY: dmem_req=1; mem_stall=1 unless dmem_ready; wait_cnt increments each cycle without dmem_ready.
REQ-021 BUSY with dmem_ready: go to IDLE; mem_stall is 0 in that cycle, so the pipeline advances on the same edge.
REQ-022 BUSY with wait_cnt==MEM_TIMEOUT-1 and no dmem_ready: go to ERR and set mem_err.
REQ-023 ERR: dmem_req=0; mem_stall=1; remain until rst.
REQ-024 mem_stall=1 forces pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_bubble high, and forces both flushes low.
REQ-025 Load-use hazard = ex_memread & ex_rd!=0 & ((id_rs1_used & ex_rd==id_rs1) | (id_rs2_used & ex_rd==id_rs2)).
REQ-026 Load-use response, when mem_stall=0 and ex_redirect=0: pc_stall=1, ifid_stall=1 and idex_flush=1 for exactly one cycle.
REQ-027 Redirect, when mem_stall=0: ifid_flush=1 and idex_flush=1, no stalls. Redirect overrides a simultaneous load-use hazard.
REQ-028 A redirect arriving during mem_stall is honoured in the first cycle mem_stall is 0; the frozen EX register keeps ex_redirect valid, so no storage is required.
REQ-029 stall_cnt increments by 1 each cycle pc_stall=1 and wraps from 2^32-1 to 0.
REQ-030 All stall and flush outputs are combinational from the current state and inputs; there is zero-cycle latency from hazard to control.

Reset
REQ-031 On rst: state=IDLE, wait_cnt=0, mem_err=0, stall_cnt=0.
REQ-032 While rst=1, all stall, flush and bubble outputs and dmem_req are 0.
REQ-033 rst asserted in BUSY or ERR takes effect at the next edge; the outstanding access is abandoned.

Structure
REQ-034 Shared package pipe_ctrl_pkg holds the FSM state encoding (IDLE=2'd0, BUSY=2'd1, ERR=2'd2) and the default MEM_TIMEOUT constant.
REQ-035 The memory FSM and wait counter are one sub-module, dmem_handshake_fsm (ports: clk, rst, mem_acc, dmem_ready, dmem_req, mem_stall, mem_err).
REQ-036 The hazard and priority logic stays in the top module.

Verification
REQ-037 ex_memread=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> one cycle of pc_stall=1, ifid_stall=1, idex_flush=1; with ex_rd=0, no response.
REQ-038 Load-use hazard and ex_redirect=1 in the same cycle -> ifid_flush=1, idex_flush=1, pc_stall=0.
REQ-039 mem_acc=1 with dmem_ready arriving 3 cycles later -> dmem_req high for 4 cycles, all stalls high for 3 cycles, stall_cnt=3.
REQ-040 mem_acc=1, dmem_ready never, MEM_TIMEOUT=15 -> ERR entered after 15 cycles, mem_err=1, stalls stuck high; rst clears everything.
REQ-041 ex_redirect=1 during a 2-cycle memory wait -> flushes stay 0 during the wait and assert in the release cycle.
REQ-042 stall_cnt preloaded to 32'hFFFFFFFF via force, one stall cycle -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and defaults for the pipeline hazard controller
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam int MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/dmem_handshake_fsm.sv
// rtl/dmem_handshake_fsm.sv - data-memory request/wait handshake with timeout to a sticky error
module dmem_handshake_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_acc,
  input  logic dmem_ready,
  output logic dmem_req,
  output logic mem_stall,
  output logic mem_err
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  logic [1:0] state;
  logic [3:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_acc && !dmem_ready) begin
            state    <= ST_BUSY;
            wait_cnt <= 4'd0;
          end
        end
        ST_BUSY: begin
          if (dmem_ready) begin
            state <= ST_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= ST_ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A first-cycle miss in IDLE already has to hold the pipeline.
  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          dmem_req  = mem_acc;
          mem_stall = mem_acc & ~dmem_ready;
        end
        ST_BUSY: begin
          dmem_req  = 1'b1;
          mem_stall = ~dmem_ready;
        end
        ST_ERR: begin
          dmem_req  = 1'b0;
          mem_stall = 1'b1;
        end
        default: begin
          dmem_req  = 1'b0;
          mem_stall = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush priority for load-use, redirect and memory-wait hazards
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_redirect,
  input  logic        mem_acc,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        memwb_bubble,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mem_err,
  output logic [31:0] stall_cnt
);

  logic mem_stall;
  logic load_use;

  dmem_handshake_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_dmem_fsm (
    .clk       (clk),
    .rst       (rst),
    .mem_acc   (mem_acc),
    .dmem_ready(dmem_ready),
    .dmem_req  (dmem_req),
    .mem_stall (mem_stall),
    .mem_err   (mem_err)
  );

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (ex_rd == id_rs1)) ||
                     (id_rs2_used && (ex_rd == id_rs2)));

  // Memory wait freezes everything; a frozen EX keeps ex_redirect alive until release.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
      end else if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (pc_stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_memread, ex_redirect, mem_acc, dmem_ready;
  logic        dmem_req, pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_bubble;
  logic        ifid_flush, idex_flush, mem_err;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_acc(mem_acc), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .memwb_bubble(memwb_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [7:0]  ctl;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          req_seen;
  string       scen;

  // reference model: 0 idle, 1 waiting, 2 error
  int          m_st;
  int          m_wait;
  logic        m_err;
  logic [31:0] m_cnt;
  logic [31:0] cnt0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", scen, tag, got, exp);
    end
  endtask

  // {dmem_req, pc, ifid_s, idex_s, exmem_s, bubble, ifid_f, idex_f}
  function automatic logic [7:0] exp_ctl();
    logic req, stl, lu;
    if (rst) return 8'h00;
    case (m_st)
      0:       begin req = mem_acc; stl = mem_acc && !dmem_ready; end
      1:       begin req = 1'b1;    stl = !dmem_ready;            end
      default: begin req = 1'b0;    stl = 1'b1;                   end
    endcase
    lu = ex_memread && ex_rd != 0 &&
         ((id_rs1_used && ex_rd == id_rs1) || (id_rs2_used && ex_rd == id_rs2));
    if (stl)              return {req, 7'b1111100};
    else if (ex_redirect) return {req, 7'b0000011};
    else if (lu)          return {req, 7'b1100001};
    return {req, 7'b0000000};
  endfunction

  task automatic model_update(input logic pcs);
    if (rst) begin
      m_st = 0; m_wait = 0; m_err = 1'b0; m_cnt = 32'd0;
    end else begin
      if (pcs) m_cnt = m_cnt + 32'd1;
      if (m_st == 0) begin
        if (mem_acc && !dmem_ready) begin m_st = 1; m_wait = 0; end
      end else if (m_st == 1) begin
        if (dmem_ready)            m_st = 0;
        else if (m_wait == TO - 1) begin m_st = 2; m_err = 1'b1; end
        else                       m_wait++;
      end
    end
  endtask

  task automatic step();
    exp_t e, o;
    e.ctl = exp_ctl();
    e.err = m_err;
    e.cnt = m_cnt;
    sb.push_back(e);
    @(negedge clk); #1;
    o = sb.pop_front();
    chk("ctl", {24'd0, dmem_req, pc_stall, ifid_stall, idex_stall, exmem_stall,
                memwb_bubble, ifid_flush, idex_flush}, {24'd0, o.ctl});
    chk("err", {31'd0, mem_err}, {31'd0, o.err});
    chk("cnt", stall_cnt, o.cnt);
    if (dmem_req === 1'b1) req_seen++;
    @(posedge clk); #1;
    model_update(o.ctl[6]);
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_memread = 1'b0;
    ex_redirect = 1'b0; mem_acc = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_st = 0; m_wait = 0; m_err = 1'b0; m_cnt = 32'd0;

    scen = "reset";
    mem_acc = 1'b1; ex_redirect = 1'b1;
    step(); step();
    idle_inputs();
    rst = 1'b0;
    scen = "idle"; step();

    scen = "lu_rs2";
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    id_rs1 = 5'd3; id_rs1_used = 1'b1;
    step();
    ex_memread = 1'b0; step();
    scen = "lu_rd0";
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; step();
    scen = "lu_rs1";
    ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd1; step();
    scen = "lu_unused";
    id_rs1_used = 1'b0; step();
    scen = "redir_lu";
    id_rs1_used = 1'b1; ex_redirect = 1'b1; step();
    idle_inputs();

    scen = "mem3";
    cnt0 = m_cnt; req_seen = 0;
    mem_acc = 1'b1; dmem_ready = 1'b0;
    repeat (3) step();
    dmem_ready = 1'b1; step();
    idle_inputs(); step();
    chk("delta", stall_cnt - cnt0, 32'd3);
    chk("req_cycles", req_seen, 32'd4);

    scen = "mem_redir";
    ex_redirect = 1'b1; mem_acc = 1'b1; dmem_ready = 1'b0;
    repeat (2) step();
    dmem_ready = 1'b1; step();
    idle_inputs(); step();

    scen = "random";
    for (int i = 0; i < 200; i++) begin
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      ex_rd       = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      ex_memread  = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 3) == 0);
      mem_acc     = 1'($urandom_range(0, 1));
      dmem_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    idle_inputs();

    scen = "timeout";
    rst = 1'b1; step();
    rst = 1'b0;
    mem_acc = 1'b1; dmem_ready = 1'b0;
    repeat (15) step();
    chk("err_pre", {31'd0, mem_err}, 32'd0);
    step();
    chk("err_post", {31'd0, mem_err}, 32'd1);
    repeat (2) step();
    dmem_ready = 1'b1; step();
    rst = 1'b1; step();
    rst = 1'b0; idle_inputs(); step();
    chk("err_cleared", {31'd0, mem_err}, 32'd0);
    chk("cnt_cleared", stall_cnt, 32'd0);

    scen = "wrap";
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    m_cnt = 32'hFFFF_FFFF;
    mem_acc = 1'b1; dmem_ready = 1'b0; step();
    chk("wrap0", stall_cnt, 32'd0);
    dmem_ready = 1'b1; step();
    idle_inputs(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
